bfloat_lane_serializer: RTL and testbench
=========================================

BFLOAT_LANE_SERIALIZER -- requirements
Module: bfloat_lane_serializer

Interface
REQ-001 SHALL have parameter N, default 2: number of packed bfloat16 lanes per input word; legal range N >= 1.
REQ-002 SHALL have localparam LW = (N > 1) ? $clog2(N) : 1: lane index width.
REQ-003 SHALL have port clk1  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst1_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  packed word offered.
REQ-006 SHALL have port in_ready  output  1  packed word accepted when in_valid && in_ready at a rising edge.
REQ-007 SHALL have port in_data  input  16*N  packed lanes; lane i at bits [16*i+15 : 16*i].
REQ-008 SHALL have port out_valid  output  1  a lane beat is presented.
REQ-009 SHALL have port out_ready  input  1  beat consumed when out_valid && out_ready at a rising edge.
REQ-010 SHALL have port out_data  output  16  current bfloat16 lane value.
REQ-011 SHALL have port out_lane  output  LW  index of the current lane.
REQ-012 SHALL have port out_last  output  1  current beat is lane N-1.
REQ-013 SHALL have port out_nan  output  1  current lane is NaN.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and SHIFT.
REQ-015 In IDLE: in_ready = 1 and out_valid = 0; on accept, SHALL capture in_data into a 16*N holding register, set lane = 0 and enter SHIFT.
REQ-016 In SHIFT: out_valid = 1; out_data = holding[16*lane +: 16]; out_lane = lane; out_last = (lane == N-1).
REQ-017 Lane order SHALL be lane 0 (LSBs) first and lane N-1 last.
REQ-018 Latency: the first beat SHALL appear in the cycle after the accepting edge.
REQ-019 On a beat with lane < N-1: lane SHALL increment by 1.
REQ-020 On a beat with lane == N-1: in_ready SHALL be 1 in that cycle (in_ready = IDLE || (SHIFT && out_last && out_ready)).
REQ-021 If in_valid is also 1 on that beat, the new word SHALL be captured with lane = 0 and state staying in SHIFT, giving no bubble; otherwise the FSM SHALL return to IDLE.
REQ-022 While out_valid && !out_ready: out_data, out_lane, out_last and out_nan SHALL hold stable, and in_ready SHALL be 0.
REQ-023 out_nan SHALL be 1 when out_data[14:7] == 8'hFF and out_data[6:0] != 0; +/-inf and all other encodings SHALL give 0.
REQ-024 Sustained throughput SHALL be one beat per cycle, N beats per word.
REQ-025 For N = 1: out_lane SHALL be constant 0, out_last SHALL be constant 1 in SHIFT, and every word SHALL be a single beat.
REQ-026 Holding register contents SHALL NOT change except on accept.

Reset
REQ-027 While rst1_n = 0: state = IDLE, lane = 0, holding = 0, out_valid = 0, out_last = 0, out_nan = 0, out_data = 16'h0000, and in_ready = 0.
REQ-028 Reset asserted mid-word SHALL discard the remaining lanes; after release, the next accepted word SHALL start at lane 0.

Structure
REQ-029 Shared package bf16_pkg SHALL hold: typedef bf16_t (16-bit), BF16_EXP_W = 8, BF16_MANT_W = 7, BF16_EXP_MAX = 8'hFF, and the serializer state enum.
REQ-030 One sub-module, bfloat_class, SHALL be instantiated: a combinational bf16 classifier (NaN/inf/zero outputs) that drives out_nan.

Verification
REQ-031 N=2, out_ready = 1, single in_valid pulse with in_data = 32'h4049_3F80 -> next cycle 3F80/lane0/last0, then 4049/lane1/last1, then out_valid = 0.
REQ-032 Same word, out_ready = 0 for 3 cycles on lane 0 -> out_data holds 3F80 and in_ready = 0 throughout; 4049 follows once out_ready = 1.
REQ-033 in_valid held high with words 32'h4049_3F80 then 32'hC000_0000, out_ready = 1 -> 4 consecutive beats 3F80, 4049, 0000, C000 with no gap.
REQ-034 Lanes 7FC1, 7F80, FFFF, 0000 across two words -> out_nan = 1, 0, 1, 0.
REQ-035 rst1_n pulsed low after lane-0 beat -> out_valid drops immediately; next word 32'h1111_2222 emits 2222 on lane 0.
REQ-036 N=1, words 16'h3F80 then 16'h7FC0 back-to-back -> two beats, out_last = 1 each, out_nan = 0 then 1.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared bfloat16 types and constants for the lane serializer.
// Also holds the serializer FSM state type.
package bf16_pkg;

  typedef logic [15:0] bf16_t;

  localparam int unsigned BF16_EXP_W  = 8;
  localparam int unsigned BF16_MANT_W = 7;
  localparam logic [BF16_EXP_W-1:0] BF16_EXP_MAX = 8'hFF;

  typedef enum logic {
    StIdle,
    StShift
  } ser_state_e;

endpackage

// File: rtl/bfloat_lane_serializer_if.sv
// Handshake bundle for the lane serializer: packed-word input side and lane-beat output side.
// The slave modport belongs to the serializer; the master modport belongs to its environment.
interface bfloat_lane_serializer_if
  import bf16_pkg::*;
#(
  parameter int unsigned N = 2
);

  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [16*N-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  bf16_t             out_data;
  logic [LW-1:0]     out_lane;
  logic              out_last;
  logic              out_nan;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, out_nan
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, out_nan
  );

endinterface

// File: rtl/bfloat_class.sv
// Combinational bfloat16 classifier: flags NaN, +/-infinity and +/-zero.
module bfloat_class
  import bf16_pkg::*;
(
  input  bf16_t value,
  output logic  is_nan,
  output logic  is_inf,
  output logic  is_zero
);

  logic [BF16_EXP_W-1:0]  exp_f;
  logic [BF16_MANT_W-1:0] mant_f;

  assign exp_f  = value[14:7];
  assign mant_f = value[6:0];

  assign is_nan  = (exp_f == BF16_EXP_MAX) && (mant_f != '0);
  assign is_inf  = (exp_f == BF16_EXP_MAX) && (mant_f == '0);
  assign is_zero = (exp_f == '0) && (mant_f == '0);

endmodule

// File: rtl/bfloat_lane_serializer.sv
// Serializes an N-lane packed bfloat16 word into N single-lane beats, lane 0 first,
// accepting the next word on the last beat so back-to-back words have no bubble.
module bfloat_lane_serializer
  import bf16_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input logic                   clk1,
  input logic                   rst1_n,
  bfloat_lane_serializer_if.slave bus
);

  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;

  ser_state_e        state_q, state_d;
  logic [LW-1:0]     lane_q, lane_d;
  bf16_t [N-1:0]     hold_q, hold_d;

  logic shift;
  logic last;
  logic accept;
  logic is_inf;
  logic is_zero;

  assign shift = (state_q == StShift);
  assign last  = (lane_q == LW'(N - 1));

  // Gated by reset so nothing is accepted while reset is held.
  assign bus.in_ready  = rst1_n && (!shift || (last && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = shift;
  assign bus.out_last  = shift && last;
  assign bus.out_lane  = lane_q;

  if (N == 1) begin : g_single
    assign bus.out_data = hold_q[0];
  end else begin : g_multi
    assign bus.out_data = hold_q[lane_q];
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          hold_d  = bus.in_data;
          lane_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.out_ready) begin
          if (!last) begin
            lane_d = lane_q + LW'(1);
          end else if (accept) begin
            hold_d = bus.in_data;
            lane_d = '0;
          end else begin
            lane_d  = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      state_q <= StIdle;
      lane_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      hold_q  <= hold_d;
    end
  end

  bfloat_class u_class (
    .value   (bus.out_data),
    .is_nan  (bus.out_nan),
    .is_inf  (is_inf),
    .is_zero (is_zero)
  );

  // The three classes are disjoint encodings.
  class_exclusive_a : assert property (@(posedge clk1) disable iff (!rst1_n)
    !(bus.out_nan && (is_inf || is_zero)) && !(is_inf && is_zero));

endmodule

// File: tb/tb_bfloat_lane_serializer.sv
// Self-checking bench: an N=2 serializer checked every cycle against a beat-queue model,
// plus literal expectations for directed scenarios and an N=1 instance.
module tb_bfloat_lane_serializer;

  logic clk1 = 1'b0;
  logic rst1_n;

  always #5 clk1 = ~clk1;

  bfloat_lane_serializer_if #(.N(2)) a ();
  bfloat_lane_serializer_if #(.N(1)) b ();

  bfloat_lane_serializer #(.N(2)) u_dut2 (
    .clk1   (clk1),
    .rst1_n (rst1_n),
    .bus    (a)
  );

  bfloat_lane_serializer #(.N(1)) u_dut1 (
    .clk1   (clk1),
    .rst1_n (rst1_n),
    .bus    (b)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic is_nan_model(input logic [15:0] v);
    int e, m;
    e = (v >> 7) & 255;
    m = v & 127;
    return (e == 255) && (m != 0);
  endfunction

  // Model: queue of beats still owed for the N=2 instance.
  typedef struct {
    logic [15:0] d;
    int          lane;
  } beat_t;
  beat_t q[$];

  always @(negedge clk1) begin
    if (!rst1_n) begin
      q.delete();
      chk("rst_in_ready", 32'(a.in_ready), 32'd0);
      chk("rst_out_valid", 32'(a.out_valid), 32'd0);
      chk("rst_out_data", 32'(a.out_data), 32'h0);
      chk("rst_out_last", 32'(a.out_last), 32'd0);
      chk("rst_out_nan", 32'(a.out_nan), 32'd0);
    end else begin
      chk("in_ready", 32'(a.in_ready),
          32'((q.size() == 0) || (q.size() == 1 && a.out_ready)));
      chk("out_valid", 32'(a.out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_data", 32'(a.out_data), 32'(q[0].d));
        chk("out_lane", 32'(a.out_lane), 32'(q[0].lane));
        chk("out_last", 32'(a.out_last), 32'(q[0].lane == 1));
        chk("out_nan", 32'(a.out_nan), 32'(is_nan_model(q[0].d)));
      end
    end
  end

  always @(posedge clk1) begin
    logic acc;
    if (rst1_n) begin
      acc = a.in_valid && ((q.size() == 0) || (q.size() == 1 && a.out_ready));
      if (q.size() != 0 && a.out_ready) void'(q.pop_front());
      if (acc) for (int i = 0; i < 2; i++) q.push_back('{a.in_data[16*i +: 16], i});
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic lit2(input string name, input logic [15:0] d, input int lane, input logic last);
    @(negedge clk1);
    chk({name, "_valid"}, 32'(a.out_valid), 32'd1);
    chk({name, "_data"}, 32'(a.out_data), 32'(d));
    chk({name, "_lane"}, 32'(a.out_lane), 32'(lane));
    chk({name, "_last"}, 32'(a.out_last), 32'(last));
  endtask

  initial begin
    rst1_n     = 1'b0;
    a.in_valid = 1'b0;
    a.in_data  = '0;
    a.out_ready = 1'b1;
    b.in_valid = 1'b0;
    b.in_data  = '0;
    b.out_ready = 1'b1;
    @(negedge clk1);
    chk("reset_b_ready", 32'(b.in_ready), 32'd0);
    chk("reset_b_valid", 32'(b.out_valid), 32'd0);
    step();
    rst1_n = 1'b1;
    step();

    // Single word, free-running sink.
    a.in_valid = 1'b1;
    a.in_data  = 32'h4049_3F80;
    step();
    a.in_valid = 1'b0;
    lit2("w1_l0", 16'h3F80, 0, 1'b0);
    step();
    lit2("w1_l1", 16'h4049, 1, 1'b1);
    step();
    @(negedge clk1);
    chk("w1_done_valid", 32'(a.out_valid), 32'd0);

    // Sink stalls three cycles on lane 0.
    step();
    a.in_valid  = 1'b1;
    a.out_ready = 1'b0;
    step();
    a.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lit2("stall_l0", 16'h3F80, 0, 1'b0);
      chk("stall_in_ready", 32'(a.in_ready), 32'd0);
      step();
    end
    a.out_ready = 1'b1;
    lit2("stall_rel_l0", 16'h3F80, 0, 1'b0);
    step();
    lit2("stall_l1", 16'h4049, 1, 1'b1);
    step();

    // Back-to-back words, no bubble.
    a.in_valid = 1'b1;
    a.in_data  = 32'h4049_3F80;
    step();
    a.in_data = 32'hC000_0000;
    lit2("b2b_0", 16'h3F80, 0, 1'b0);
    step();
    lit2("b2b_1", 16'h4049, 1, 1'b1);
    chk("b2b_in_ready", 32'(a.in_ready), 32'd1);
    step();
    a.in_valid = 1'b0;
    lit2("b2b_2", 16'h0000, 0, 1'b0);
    step();
    lit2("b2b_3", 16'hC000, 1, 1'b1);
    step();

    // NaN classification across two words: 7FC1, 7F80, FFFF, 0000.
    a.in_valid = 1'b1;
    a.in_data  = 32'h7F80_7FC1;
    step();
    a.in_data = 32'h0000_FFFF;
    @(negedge clk1);
    chk("nan_7fc1", 32'(a.out_nan), 32'd1);
    step();
    @(negedge clk1);
    chk("nan_7f80", 32'(a.out_nan), 32'd0);
    step();
    a.in_valid = 1'b0;
    @(negedge clk1);
    chk("nan_ffff", 32'(a.out_nan), 32'd1);
    step();
    @(negedge clk1);
    chk("nan_0000", 32'(a.out_nan), 32'd0);
    step();

    // Reset mid-word discards the remaining lane.
    a.in_valid = 1'b1;
    a.in_data  = 32'h4049_3F80;
    step();
    a.in_valid = 1'b0;
    lit2("rst_mid_l0", 16'h3F80, 0, 1'b0);
    step();
    rst1_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(a.out_valid), 32'd0);
    chk("rst_mid_data", 32'(a.out_data), 32'h0);
    step();
    rst1_n = 1'b1;
    step();
    a.in_valid = 1'b1;
    a.in_data  = 32'h1111_2222;
    step();
    a.in_valid = 1'b0;
    lit2("post_rst_l0", 16'h2222, 0, 1'b0);
    step();
    lit2("post_rst_l1", 16'h1111, 1, 1'b1);
    step();

    // N = 1: every word is one beat.
    b.in_valid = 1'b1;
    b.in_data  = 16'h3F80;
    step();
    b.in_data = 16'h7FC0;
    @(negedge clk1);
    chk("n1_b0_valid", 32'(b.out_valid), 32'd1);
    chk("n1_b0_data", 32'(b.out_data), 32'h3F80);
    chk("n1_b0_last", 32'(b.out_last), 32'd1);
    chk("n1_b0_lane", 32'(b.out_lane), 32'd0);
    chk("n1_b0_nan", 32'(b.out_nan), 32'd0);
    chk("n1_b0_ready", 32'(b.in_ready), 32'd1);
    step();
    b.in_valid = 1'b0;
    @(negedge clk1);
    chk("n1_b1_valid", 32'(b.out_valid), 32'd1);
    chk("n1_b1_data", 32'(b.out_data), 32'h7FC0);
    chk("n1_b1_last", 32'(b.out_last), 32'd1);
    chk("n1_b1_nan", 32'(b.out_nan), 32'd1);
    step();
    @(negedge clk1);
    chk("n1_done_valid", 32'(b.out_valid), 32'd0);
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
